// File: rtl/npu_top_core.sv
// npu_top_core: 4-lane int8 dot-product NPU with a frame-control FSM, a
// requantization stage (shift / ReLU / saturate) driven by SSFR, a result
// FIFO and a 32-bit debug PISO.
//
// state  | meaning
// IDLE   | waiting for EN_FSM; SSFR writes accepted here only
// LOAD_W | capture weight quad from DA..DD
// RUN    | capture one activation quad per cycle, FRAME_LEN in total
// DRAIN  | two cycles for the product/result pipeline to empty
module npu_top_core #(
  parameter int FRAME_LEN  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       CLKEXT,
  input  logic       RST_GLO,
  input  logic       EN_FSM,
  input  logic       EN_CONFIG,
  input  logic [7:0] DA,
  input  logic [7:0] DB,
  input  logic [7:0] DC,
  input  logic [7:0] DD,
  input  logic       RD_EN,
  input  logic       EN_PISO_DEB,
  input  logic       CLR_PISO_DEB,
  input  logic       SHIFT_DEB,
  input  logic       SEL_CON,
  output logic [7:0] D_OUT,
  output logic       FULL,
  output logic       EMPTY
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_LEN);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3
  } state_t;

  state_t             state;
  logic [15:0]        ssfr;
  logic signed [7:0]  w0, w1, w2, w3;
  logic signed [7:0]  x0, x1, x2, x3;
  logic [CW-1:0]      act_cnt;
  logic               drain_cnt;
  logic               act_vld;

  logic signed [15:0] p0, p1, p2, p3;
  logic               prod_vld;

  logic signed [17:0] acc;
  logic signed [17:0] shifted;
  logic [7:0]         res_byte;

  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        fifo_cnt;
  logic [7:0]         rd_reg;
  logic [7:0]         last_result;
  logic               fifo_wr, fifo_pop;

  logic [31:0]        piso;

  // Frame sequencing, SSFR writes, weight and activation capture
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      state     <= IDLE;
      ssfr      <= 16'h2280;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      x3        <= '0;
      act_cnt   <= '0;
      drain_cnt <= 1'b0;
      act_vld   <= 1'b0;
    end else begin
      act_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (EN_CONFIG) ssfr <= {DA, DB};
          if (EN_FSM) state <= LOAD_W;
        end
        LOAD_W: begin
          w0      <= DA;
          w1      <= DB;
          w2      <= DC;
          w3      <= DD;
          act_cnt <= '0;
          state   <= RUN;
        end
        RUN: begin
          x0      <= DA;
          x1      <= DB;
          x2      <= DC;
          x3      <= DD;
          act_vld <= 1'b1;
          if (act_cnt == CW'(FRAME_LEN - 1)) begin
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            act_cnt <= act_cnt + CW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            drain_cnt <= 1'b0;
            state     <= IDLE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Product stage: four signed 8x8 multiplies registered one cycle after capture
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      p0       <= '0;
      p1       <= '0;
      p2       <= '0;
      p3       <= '0;
      prod_vld <= 1'b0;
    end else begin
      p0       <= 16'(w0) * 16'(x0);
      p1       <= 16'(w1) * 16'(x1);
      p2       <= 16'(w2) * 16'(x2);
      p3       <= 16'(w3) * 16'(x3);
      prod_vld <= act_vld;
    end
  end

  // Sum, arithmetic shift, optional ReLU and optional saturation to int8
  always_comb begin
    acc      = 18'(p0) + 18'(p1) + 18'(p2) + 18'(p3);
    shifted  = acc >>> ssfr[11:8];
    if (ssfr[7] && shifted < 0) shifted = '0;
    res_byte = shifted[7:0];
    if (ssfr[13]) begin
      if (shifted > 18'sd127)       res_byte = 8'h7F;
      else if (shifted < -18'sd128) res_byte = 8'h80;
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write
  always_comb begin
    FULL     = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    EMPTY    = (fifo_cnt == '0);
    fifo_pop = RD_EN && !EMPTY;
    fifo_wr  = prod_vld && (!FULL || fifo_pop);
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge CLKEXT) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= res_byte;
  end

  // FIFO pointers, occupancy, read register and last computed result
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      rd_reg      <= '0;
      last_result <= '0;
    end else begin
      if (prod_vld) last_result <= res_byte;
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop) begin
        rd_reg <= fifo_mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({fifo_wr, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Debug PISO: clear beats load beats shift
  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      piso <= '0;
    end else if (CLR_PISO_DEB) begin
      piso <= '0;
    end else if (EN_PISO_DEB) begin
      piso <= {ssfr, last_result, 3'b000, FULL, EMPTY, state};
    end else if (SHIFT_DEB) begin
      piso <= {8'h00, piso[31:8]};
    end
  end

  // Output byte select between registered sources
  always_comb begin
    D_OUT = SEL_CON ? rd_reg : piso[7:0];
  end

endmodule

// File: tb/tb_npu_top_core.sv
// Bench for npu_top_core: randomized frames checked against a behavioural
// model (integer dot product + queue-based FIFO with per-edge arrival times).
module tb_npu_top_core;

  localparam int FRAME_LEN  = 8;
  localparam int FIFO_DEPTH = 16;

  logic       CLKEXT = 1'b0;
  logic       RST_GLO, EN_FSM, EN_CONFIG, RD_EN;
  logic       EN_PISO_DEB, CLR_PISO_DEB, SHIFT_DEB, SEL_CON;
  logic [7:0] DA, DB, DC, DD;
  logic [7:0] D_OUT;
  logic       FULL, EMPTY;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]  q[$];
  int          due_q[$];
  logic [7:0]  val_q[$];
  logic [15:0] m_ssfr;
  logic [7:0]  m_last;
  logic [7:0]  last_rd;
  logic [31:0] acts [FRAME_LEN];

  npu_top_core #(.FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .EN_FSM(EN_FSM), .EN_CONFIG(EN_CONFIG),
    .DA(DA), .DB(DB), .DC(DC), .DD(DD), .RD_EN(RD_EN),
    .EN_PISO_DEB(EN_PISO_DEB), .CLR_PISO_DEB(CLR_PISO_DEB), .SHIFT_DEB(SHIFT_DEB),
    .SEL_CON(SEL_CON), .D_OUT(D_OUT), .FULL(FULL), .EMPTY(EMPTY)
  );

  always #5 CLKEXT = ~CLKEXT;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] ref_result(input logic [31:0] wq, input logic [31:0] xq,
                                            input logic [15:0] cfg);
    int acc, s;
    acc = 0;
    for (int i = 0; i < 4; i++)
      acc += int'($signed(wq[8*i +: 8])) * int'($signed(xq[8*i +: 8]));
    s = acc >>> cfg[11:8];
    if (cfg[7] && s < 0) s = 0;
    if (cfg[13]) begin
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
    end
    return 8'(s);
  endfunction

  // One rising edge: model pops first, then accepts a due result if room remains.
  task automatic step();
    bit         pop;
    logic [7:0] exp_rd, v;
    pop    = RD_EN && (q.size() > 0);
    exp_rd = 8'h00;
    @(posedge CLKEXT);
    cyc++;
    if (pop) exp_rd = q.pop_front();
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      v      = val_q.pop_front();
      m_last = v;
      if (q.size() < FIFO_DEPTH) q.push_back(v);
    end
    #1;
    if (pop) begin
      last_rd = exp_rd;
      if (SEL_CON) begin
        checks++;
        if (D_OUT !== exp_rd) begin
          errors++;
          $display("FAIL pop_data: got %h want %h cyc %0d", D_OUT, exp_rd, cyc);
        end
      end
    end
    checks++;
    if (EMPTY !== (q.size() == 0)) begin
      errors++;
      $display("FAIL empty: got %b want %b cyc %0d", EMPTY, (q.size() == 0), cyc);
    end
    checks++;
    if (FULL !== (q.size() == FIFO_DEPTH)) begin
      errors++;
      $display("FAIL full: got %b want %b cyc %0d", FULL, (q.size() == FIFO_DEPTH), cyc);
    end
  endtask

  task automatic do_reset();
    RST_GLO = 1'b1;
    #2;
    q.delete(); due_q.delete(); val_q.delete();
    m_ssfr = 16'h2280; m_last = 8'h00; last_rd = 8'h00;
    checks++;
    if (EMPTY !== 1'b1 || FULL !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got empty %b full %b want 1 0", EMPTY, FULL);
    end
    SEL_CON = 1'b1; #1;
    checks++;
    if (D_OUT !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdreg: got %h want 00", D_OUT);
    end
    SEL_CON = 1'b0; #1;
    checks++;
    if (D_OUT !== 8'h00) begin
      errors++;
      $display("FAIL reset_piso: got %h want 00", D_OUT);
    end
    SEL_CON = 1'b1;
    @(negedge CLKEXT);
    RST_GLO = 1'b0;
    @(posedge CLKEXT);
    #1;
  endtask

  // Load (with SHIFT also high, load must win), shift out all bytes, then clear.
  task automatic check_piso();
    logic [31:0] exp;
    logic        f, e;
    f   = (q.size() == FIFO_DEPTH);
    e   = (q.size() == 0);
    exp = {m_ssfr, m_last, 3'b000, f, e, 3'b000};
    SEL_CON = 1'b0; RD_EN = 1'b0;
    EN_PISO_DEB = 1'b1; SHIFT_DEB = 1'b1;
    step();
    EN_PISO_DEB = 1'b0;
    for (int b = 0; b < 5; b++) begin
      logic [7:0] want;
      want = (b < 4) ? exp[8*b +: 8] : 8'h00;
      checks++;
      if (D_OUT !== want) begin
        errors++;
        $display("FAIL piso_byte%0d: got %h want %h", b, D_OUT, want);
      end
      if (b < 4) step();
    end
    SHIFT_DEB = 1'b0; EN_PISO_DEB = 1'b1; CLR_PISO_DEB = 1'b1;
    step();
    checks++;
    if (D_OUT !== 8'h00) begin
      errors++;
      $display("FAIL piso_clear: got %h want 00", D_OUT);
    end
    EN_PISO_DEB = 1'b0; CLR_PISO_DEB = 1'b0; SEL_CON = 1'b1;
  endtask

  task automatic write_cfg(input logic [15:0] v);
    EN_CONFIG = 1'b1; DA = v[15:8]; DB = v[7:0];
    step();
    EN_CONFIG = 1'b0;
    m_ssfr = v;
  endtask

  task automatic run_frame(input logic [31:0] wq, input bit pop_each, input bit noise);
    SEL_CON = 1'b1; RD_EN = pop_each;
    EN_FSM = 1'b1;
    step();
    EN_FSM = noise;
    {DA, DB, DC, DD} = wq;
    step();
    for (int k = 0; k < FRAME_LEN; k++) begin
      {DA, DB, DC, DD} = acts[k];
      if (noise) begin
        EN_FSM    = 1'($urandom_range(0, 1));
        EN_CONFIG = 1'($urandom_range(0, 1));
      end
      due_q.push_back(cyc + 3);
      val_q.push_back(ref_result(wq, acts[k], m_ssfr));
      step();
    end
    EN_FSM = 1'b0; EN_CONFIG = 1'b0;
    {DA, DB, DC, DD} = $urandom;
    step();
    step();
    RD_EN = 1'b0;
  endtask

  task automatic pop_all();
    int guard;
    guard = 0;
    SEL_CON = 1'b1;
    while (q.size() > 0 && guard < 40) begin
      RD_EN = 1'b1;
      step();
      guard++;
    end
    RD_EN = 1'b1;
    step();
    RD_EN = 1'b0;
    checks++;
    if (D_OUT !== last_rd || EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL pop_empty_hold: got %h empty %b want %h empty 1", D_OUT, EMPTY, last_rd);
    end
  endtask

  task automatic rand_acts();
    for (int k = 0; k < FRAME_LEN; k++) acts[k] = $urandom;
  endtask

  task automatic test_reset();
    do_reset();
    check_piso();
  endtask

  task automatic test_default_frame();
    for (int k = 0; k < FRAME_LEN; k++) acts[k] = {4{8'(8'hD0 + k)}};
    run_frame(32'hD800D808, 1'b0, 1'b0);
    pop_all();
    check_piso();
  endtask

  task automatic test_shift_nosat();
    write_cfg(16'h0400);
    for (int k = 0; k < FRAME_LEN; k++) acts[k] = 32'hF0F0F0F0;
    run_frame(32'h01010101, 1'b0, 1'b0);
    pop_all();
    check_piso();
  endtask

  task automatic test_relu_only();
    write_cfg(16'h0080);
    for (int k = 0; k < FRAME_LEN; k++) acts[k] = 32'hF0F0F0F0;
    run_frame(32'h01010101, 1'b0, 1'b0);
    pop_all();
  endtask

  task automatic test_fifo_full();
    write_cfg(16'h0300);
    for (int f = 0; f < 3; f++) begin
      rand_acts();
      run_frame($urandom, 1'b0, 1'b0);
    end
    check_piso();
    pop_all();
  endtask

  task automatic test_full_with_pop();
    write_cfg(16'h2580);
    for (int f = 0; f < 2; f++) begin
      rand_acts();
      run_frame($urandom, 1'b0, 1'b0);
    end
    rand_acts();
    run_frame($urandom, 1'b1, 1'b1);
    check_piso();
    pop_all();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      write_cfg(16'($urandom));
      rand_acts();
      run_frame($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rand_acts();
      run_frame($urandom, 1'($urandom_range(0, 1)), 1'b0);
      check_piso();
      pop_all();
    end
  endtask

  task automatic test_reset_mid_run();
    write_cfg(16'h0400);
    rand_acts();
    SEL_CON = 1'b1;
    EN_FSM = 1'b1;
    step();
    EN_FSM = 1'b0;
    {DA, DB, DC, DD} = 32'h7F7F7F7F;
    step();
    for (int k = 0; k < 3; k++) begin
      {DA, DB, DC, DD} = acts[k];
      due_q.push_back(cyc + 3);
      val_q.push_back(ref_result(32'h7F7F7F7F, acts[k], m_ssfr));
      step();
    end
    do_reset();
    for (int k = 0; k < 4; k++) step();
    check_piso();
  endtask

  initial begin
    RST_GLO = 1'b1; EN_FSM = 1'b0; EN_CONFIG = 1'b0; RD_EN = 1'b0;
    EN_PISO_DEB = 1'b0; CLR_PISO_DEB = 1'b0; SHIFT_DEB = 1'b0; SEL_CON = 1'b1;
    DA = 8'h00; DB = 8'h00; DC = 8'h00; DD = 8'h00;
    m_ssfr = 16'h2280; m_last = 8'h00; last_rd = 8'h00;
    test_reset();
    test_default_frame();
    test_shift_nosat();
    test_relu_only();
    test_fifo_full();
    test_full_with_pop();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
